// File: rtl/led_pattern_ticker_pkg.sv
// Shared types and elaboration helpers for the LED pattern ticker.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] gray(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/led_pattern_ticker_btn_debounce.sv
// Button synchroniser and debouncer; emits a one-cycle pulse when a press is accepted.
module btn_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic XTAL_IN,
    input  logic RST_N,
    input  logic BTN_USER,
    output logic press
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge XTAL_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_sync  <= 2'b11;
            r_db    <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], BTN_USER};
            r_press <= 1'b0;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Only the falling (press) edge of the debounced level is reported.
                r_db    <= r_sync[1];
                r_cnt   <= '0;
                r_press <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/led_pattern_ticker.sv
// Tick prescaler, button-selected mode register and LED pattern generator.
module led_pattern_ticker
    import led_pkg::*;
#(
    parameter int NUM_LEDS        = 6,
    parameter int CLK_HZ          = 27000000,
    parameter int TICK_HZ         = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                XTAL_IN,
    input  logic                RST_N,
    input  logic                BTN_USER,
    output logic [NUM_LEDS-1:0] LED,
    output logic [1:0]          MODE,
    output logic                TICK
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = clog2(DIV);
    localparam int POSW = clog2(NUM_LEDS);
    localparam logic [PW-1:0]       PRE_LAST = PW'(DIV - 1);
    localparam logic [POSW-1:0]     POS_LAST = POSW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LED_XOR  = (ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}} : '0;

    logic                w_press;
    logic                w_tick;
    mode_e               r_mode, w_mode_nxt;
    logic [NUM_LEDS-1:0] r_cnt, w_cnt_nxt;
    logic [POSW-1:0]     r_pos, w_pos_nxt;
    logic                r_dir, w_dir_nxt;
    logic [PW-1:0]       r_pre, w_pre_nxt;
    logic [NUM_LEDS-1:0] w_pat;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .XTAL_IN  (XTAL_IN),
        .RST_N    (RST_N),
        .BTN_USER (BTN_USER),
        .press    (w_press)
    );

    // A press restarts the pattern and swallows any tick due in the same cycle.
    assign w_tick    = (r_pre == PRE_LAST) && !w_press;
    assign w_pre_nxt = (w_press || r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;

    always_comb begin
        w_mode_nxt = r_mode;
        w_cnt_nxt  = r_cnt;
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
        if (w_press) begin
            w_mode_nxt = mode_e'(r_mode + 2'd1);
            w_cnt_nxt  = '0;
            w_pos_nxt  = '0;
            w_dir_nxt  = 1'b0;
        end else if (w_tick) begin
            case (r_mode)
                MODE_DOWN:   w_cnt_nxt = r_cnt - 1'b1;
                MODE_BOUNCE: begin
                    if (!r_dir) begin
                        if (r_pos == POS_LAST) begin
                            w_dir_nxt = 1'b1;
                            w_pos_nxt = r_pos - 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + 1'b1;
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_dir_nxt = 1'b0;
                            w_pos_nxt = r_pos + 1'b1;
                        end else begin
                            w_pos_nxt = r_pos - 1'b1;
                        end
                    end
                end
                default:     w_cnt_nxt = r_cnt + 1'b1;
            endcase
        end
    end

    always_comb begin
        w_pat = w_cnt_nxt;
        case (w_mode_nxt)
            MODE_BOUNCE: w_pat = NUM_LEDS'(1) << w_pos_nxt;
            MODE_GRAY:   w_pat = NUM_LEDS'(gray(32'(w_cnt_nxt)));
            default:     w_pat = w_cnt_nxt;
        endcase
    end

    always_ff @(posedge XTAL_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_mode <= MODE_UP;
            r_cnt  <= '0;
            r_pos  <= '0;
            r_dir  <= 1'b0;
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_led  <= LED_XOR;
        end else begin
            r_mode <= w_mode_nxt;
            r_cnt  <= w_cnt_nxt;
            r_pos  <= w_pos_nxt;
            r_dir  <= w_dir_nxt;
            r_pre  <= w_pre_nxt;
            r_tick <= w_tick;
            r_led  <= w_pat ^ LED_XOR;
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;
    assign TICK = r_tick;

endmodule

// File: tb/tb_led_pattern_ticker.sv
// Directed bench for led_pattern_ticker at DIV=10, DEBOUNCE_CYCLES=4, 4 LEDs, active-high.
module tb_led_pattern_ticker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    led_pattern_ticker #(
        .NUM_LEDS(4), .CLK_HZ(20), .TICK_HZ(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)
    ) dut (
        .XTAL_IN  (clk),
        .RST_N    (rst_n),
        .BTN_USER (btn),
        .LED      (led),
        .MODE     (mode),
        .TICK     (tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 40);
        chk("tick_seen", tick, 1);
    endtask

    // Press latency: 2 sync + 4 debounce + 1 register = MODE moves on the 7th edge.
    task automatic press_btn(input logic [1:0] old_m, input logic [1:0] new_m, input logic [3:0] led0);
        int n;
        btn = 1'b0;
        repeat (6) @(negedge clk);
        chk("mode_before", mode, old_m);
        @(negedge clk);
        chk("mode_after", mode, new_m);
        chk("led_step0", led, led0);
        chk("tick_suppressed", tick, 0);
        btn = 1'b1;
        wait_tick(n);
        chk("tick_after_press", n, 10);
    endtask

    initial begin
        int n;
        int changes;
        logic [1:0] prev;
        logic [3:0] exp_b [7] = '{4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        logic [3:0] exp_g [4] = '{4'b0011, 4'b0010, 4'b0110, 4'b0111};

        rst_n = 1'b0;
        btn   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tick, 0);
        rst_n = 1'b1;

        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            chk("run_tick", tick, (k % 10 == 0));
            chk("run_led", led, k / 10);
        end
        chk("run_mode", mode, 0);

        for (int i = 0; i < 12; i++) begin
            wait_tick(n);
            if (i > 0) chk("up_period", n, 10);
            chk("up_led", led, (5 + i) % 16);
        end

        press_btn(2'd0, 2'd1, 4'd0);
        chk("down_led0", led, 15);
        wait_tick(n);
        chk("down_led1", led, 14);

        press_btn(2'd1, 2'd2, 4'b0001);
        chk("bounce_led0", led, 4'b0010);
        for (int i = 0; i < 7; i++) begin
            wait_tick(n);
            chk("bounce_led", led, exp_b[i]);
        end

        press_btn(2'd2, 2'd3, 4'b0000);
        chk("gray_led0", led, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            chk("gray_led", led, exp_g[i]);
        end

        btn = 1'b0;
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_mode", mode, 3);

        btn = 1'b0;
        changes = 0;
        prev = mode;
        repeat (100) begin
            @(negedge clk);
            if (mode != prev) changes++;
            prev = mode;
        end
        chk("held_changes", changes, 1);
        chk("held_mode", mode, 0);
        btn = 1'b1;
        repeat (10) @(negedge clk);

        // Align the accepted press with the edge where pre==9.
        wait_tick(n);
        chk("pre_led_nonzero", (led != 0), 1);
        repeat (3) @(negedge clk);
        press_btn(2'd0, 2'd1, 4'd0);
        chk("coinc_led", led, 15);

        press_btn(2'd1, 2'd2, 4'b0001);
        chk("bounce2_pos1", led, 4'b0010);
        wait_tick(n);
        chk("bounce2_pos2", led, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", led, 0);
        chk("async_mode", mode, 0);
        chk("async_tick", tick, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
